// File: rtl/arf_pkg.sv
// -----------------------------------------------------------------------------
// arf_pkg
// Shared parameter defaults for the arithmetic datapath family.
//   ARF_DATA_WIDTH : default operand/result width
//   ARF_MAX_TAPS   : default maximum number of beats in one accumulation group
//   ARF_CNT_W      : default tap-counter width, wide enough to hold ARF_MAX_TAPS
// -----------------------------------------------------------------------------
package arf_pkg;

  localparam int ARF_DATA_WIDTH = 32;
  localparam int ARF_MAX_TAPS   = 16;
  localparam int ARF_CNT_W      = 5;

  // Smallest counter width that can represent the value n.
  function automatic int arf_cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mac_seq_stage.sv
// -----------------------------------------------------------------------------
// mac_seq_stage
// Sequential multiply-accumulate stage. Operand beats are registered (S1),
// multiplied by an externally bound multiplier into a product register (S2),
// then summed by an externally bound adder into an accumulator. A group ends
// on a beat flagged last, or is force-closed at MAX_TAPS beats (sets ovf).
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake
//   in_a, in_b, in_last : sample, coefficient, end-of-group flag
//   mul_in_0/1, mul_out : operands to / result from the external multiplier
//   add_in_0/1, add_out : operands to / result from the external adder
//   out_valid/out_ready : result handshake
//   out_data, out_taps  : accumulated sum and number of beats in the group
//   ovf                 : sticky, a group was force-terminated at MAX_TAPS
// -----------------------------------------------------------------------------
module mac_seq_stage
  import arf_pkg::*;
#(
  parameter int DATA_WIDTH = ARF_DATA_WIDTH,
  parameter int MAX_TAPS   = ARF_MAX_TAPS,
  parameter int CNT_W      = ARF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] mul_in_0,
  output logic [DATA_WIDTH-1:0] mul_in_1,
  input  logic [DATA_WIDTH-1:0] mul_out,
  output logic [DATA_WIDTH-1:0] add_in_0,
  output logic [DATA_WIDTH-1:0] add_in_1,
  input  logic [DATA_WIDTH-1:0] add_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      out_taps,
  output logic                  ovf
);

  logic                  stall;
  logic                  s1_valid;
  logic                  s1_last;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic                  s2_valid;
  logic                  s2_last;
  logic [DATA_WIDTH-1:0] s2_prod;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]      count;
  logic                  first_beat;
  logic                  terminal;

  // The whole pipeline freezes only while a finished result waits downstream.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  assign mul_in_0 = s1_a;
  assign mul_in_1 = s1_b;

  // A new group starts from zero instead of the previous group's sum.
  assign add_in_0 = first_beat ? '0 : acc;
  assign add_in_1 = s2_prod;

  // count holds beats already folded in, so the current beat is count+1.
  assign terminal = s2_last || (count == CNT_W'(MAX_TAPS - 1));

  // Operand and product pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_prod  <= mul_out;
    end
  end

  // Accumulator, tap counter and output register. Reset discards any
  // partial group, so no result is ever produced for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      count      <= '0;
      first_beat <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_taps   <= '0;
      ovf        <= 1'b0;
    end else if (!stall) begin
      // Not stalled means any held result is being taken this cycle;
      // a terminal beat below overrides this with a fresh result.
      out_valid <= 1'b0;
      if (s2_valid) begin
        acc <= add_out;
        if (terminal) begin
          count      <= '0;
          first_beat <= 1'b1;
          out_valid  <= 1'b1;
          out_data   <= add_out;
          out_taps   <= count + 1'b1;
          if (!s2_last) ovf <= 1'b1;
        end else begin
          count      <= count + 1'b1;
          first_beat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_stage.sv
// -----------------------------------------------------------------------------
// tb_mac_seq_stage
// Directed-vector bench for mac_seq_stage with behavioural multiplier and
// adder bound to the operator ports. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_mac_seq_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_last;
  logic [31:0] mul_in_0;
  logic [31:0] mul_in_1;
  logic [31:0] mul_out;
  logic [31:0] add_in_0;
  logic [31:0] add_in_1;
  logic [31:0] add_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_taps;
  logic        ovf;

  int vectors;
  int miscompares;

  mac_seq_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .mul_in_0 (mul_in_0),
    .mul_in_1 (mul_in_1),
    .mul_out  (mul_out),
    .add_in_0 (add_in_0),
    .add_in_1 (add_in_1),
    .add_out  (add_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_taps (out_taps),
    .ovf      (ovf)
  );

  // Externally bound operators, 32-bit wrap.
  assign mul_out = mul_in_0 * mul_in_1;
  assign add_out = add_in_0 + add_in_1;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and let one rising edge pass; in_valid stays asserted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    stepCycle();
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_last  = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [31:0] data,
                             input logic [31:0] taps);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, out_data, data);
    checkOutput({tag, "_taps"}, 32'(out_taps), taps);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    out_ready   = 1'b1;
    idleInputs();

    // Reset state.
    stepCycle();
    stepCycle();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_taps", 32'(out_taps), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Two-beat group: 3*4 + 5*6 = 42, result exactly three cycles after accept.
    applyStimulus(32'd3, 32'd4, 1'b0);
    applyStimulus(32'd5, 32'd6, 1'b1);
    idleInputs();
    stepCycle();
    checkOutput("lat_c2_valid", 32'(out_valid), 32'd0);
    stepCycle();
    checkResult("grp42", 32'd42, 32'd2);
    stepCycle();
    checkOutput("grp42_cleared", 32'(out_valid), 32'd0);

    // Back-to-back single-beat groups: 4 then 7 on consecutive cycles.
    applyStimulus(32'd2, 32'd2, 1'b1);
    checkOutput("b2b_ready0", 32'(in_ready), 32'd1);
    applyStimulus(32'd1, 32'd7, 1'b1);
    checkOutput("b2b_ready1", 32'(in_ready), 32'd1);
    idleInputs();
    stepCycle();
    checkResult("b2b_first", 32'd4, 32'd1);
    checkOutput("b2b_ready2", 32'(in_ready), 32'd1);
    stepCycle();
    checkResult("b2b_second", 32'd7, 32'd1);
    stepCycle();
    checkOutput("b2b_cleared", 32'(out_valid), 32'd0);

    // Backpressure: results 6, 20, 42, 1 with no beat lost.
    out_ready = 1'b0;
    applyStimulus(32'd2, 32'd3, 1'b1);
    applyStimulus(32'd4, 32'd5, 1'b1);
    applyStimulus(32'd6, 32'd7, 1'b1);
    in_a    = 32'd1;
    in_b    = 32'd1;
    in_last = 1'b1;
    #1;
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    checkResult("stall_held0", 32'd6, 32'd1);
    stepCycle();
    stepCycle();
    checkResult("stall_held1", 32'd6, 32'd1);
    checkOutput("stall_in_ready2", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    stepCycle();
    idleInputs();
    checkResult("stall_b", 32'd20, 32'd1);
    stepCycle();
    checkResult("stall_c", 32'd42, 32'd1);
    stepCycle();
    checkResult("stall_d", 32'd1, 32'd1);
    stepCycle();
    checkOutput("stall_cleared", 32'(out_valid), 32'd0);

    // Overflow: 17 beats of 1*1 without last; 17th opens the next group.
    for (int i = 0; i < 17; i++) applyStimulus(32'd1, 32'd1, 1'b0);
    checkOutput("ovf_before", 32'(ovf), 32'd0);
    applyStimulus(32'd2, 32'd3, 1'b1);
    idleInputs();
    checkResult("ovf_group", 32'd16, 32'd16);
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    stepCycle();
    checkOutput("ovf_gap", 32'(out_valid), 32'd0);
    stepCycle();
    checkResult("ovf_next", 32'd7, 32'd2);
    checkOutput("ovf_sticky", 32'(ovf), 32'd1);
    stepCycle();

    // Reset mid-group discards the partial sum.
    applyStimulus(32'd1, 32'd2, 1'b0);
    applyStimulus(32'd3, 32'd4, 1'b0);
    idleInputs();
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("midrst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("midrst_no_out", 32'(out_valid), 32'd0);
      stepCycle();
    end
    applyStimulus(32'd9, 32'd9, 1'b1);
    idleInputs();
    stepCycle();
    stepCycle();
    checkResult("midrst_next", 32'd81, 32'd1);
    stepCycle();

    // Wrap: 2 * (0xFFFFFFFF*2) = 0xFFFFFFFC modulo 2^32.
    applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b1);
    idleInputs();
    stepCycle();
    stepCycle();
    checkResult("wrap", 32'hFFFF_FFFC, 32'd2);
    stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
